// File: rtl/ins_bundle_queue.sv
// Bundle FIFO in front of the load/store swap stage: splits each head bundle into
// issue passes that carry at most one load/store, and flags that slot for the swap.
module ins_bundle_queue #(
    parameter int unsigned des       = 4,
    parameter int unsigned source1   = 4,
    parameter int unsigned source2   = 4,
    parameter int unsigned immediate = 5,
    parameter int unsigned branch_id = 3,
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  LD_OP     = 4'd8,
    parameter logic [3:0]  ST_OP     = 4'd9,
    localparam int unsigned IW = 1 + des + source1 + source2 + 4 + branch_id + immediate,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*IW-1:0] in_ins,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*IW-1:0] out_ins,
    output logic [3:0]      out_swap,
    output logic            out_last,
    output logic [CW-1:0]   count
);

    localparam int unsigned OP_LSB = immediate + branch_id;

    logic [4*IW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      issued_q, issued_d;

    logic [4*IW-1:0] head;
    logic [3:0]      slot_vld, slot_mem, pend, pend_mem, mem_pick, pass;
    logic            last, in_any_vld, push, fire, pop;

    // Pass selection from head entry and issued mask
    always_comb begin
        head     = mem_q[rd_ptr_q];
        slot_vld = '0;
        slot_mem = '0;
        for (int k = 0; k < 4; k++) begin
            slot_vld[k] = head[k*IW + IW - 1];
            slot_mem[k] = slot_vld[k] &
                          ((head[k*IW + OP_LSB +: 4] == LD_OP) ||
                           (head[k*IW + OP_LSB +: 4] == ST_OP));
        end
        pend     = slot_vld & ~issued_q;
        pend_mem = pend & slot_mem;
        // Isolate the lowest pending memory slot
        mem_pick = pend_mem & 4'(~pend_mem + 4'd1);
        pass     = (pend & ~slot_mem) | mem_pick;
        last     = ((pend & ~pass) == 4'd0);
    end

    // Output drive; an empty queue presents an all-zero pass
    always_comb begin
        out_ins   = '0;
        out_swap  = '0;
        out_last  = 1'b0;
        out_valid = (count_q != '0) & ~flush;
        in_ready  = (count_q < CW'(DEPTH));
        count     = count_q;
        if (count_q != '0) begin
            out_ins = head;
            for (int k = 0; k < 4; k++) begin
                out_ins[k*IW + IW - 1] = pass[k];
            end
            out_swap = pass & slot_mem;
            out_last = last;
        end
    end

    // Next-state for pointers, occupancy and issued mask
    always_comb begin
        in_any_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_any_vld = in_any_vld | in_ins[k*IW + IW - 1];
        end
        push     = in_valid & in_ready & in_any_vld;
        fire     = out_valid & out_ready;
        pop      = fire & last;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            issued_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = PW'(wr_ptr_q + PW'(1));
            end
            if (pop) begin
                rd_ptr_d = PW'(rd_ptr_q + PW'(1));
                issued_d = '0;
            end else if (fire) begin
                issued_d = issued_q | pass;
            end
            count_d = CW'(count_q + CW'(push) - CW'(pop));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    // Bundle storage; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_ins;
        end
    end

endmodule

// File: tb/tb_ins_bundle_queue.sv
// Directed bench for ins_bundle_queue: split passes, backpressure, flush, reset, empty bundles.
module tb_ins_bundle_queue;

    localparam int unsigned IW = 25;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] LD  = 4'd8;
    localparam logic [3:0] ST  = 4'd9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4*IW-1:0] in_ins = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4*IW-1:0] out_ins;
    logic [3:0]      out_swap;
    logic            out_last;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    ins_bundle_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_swap(out_swap), .out_last(out_last), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4*IW-1:0] got, input logic [4*IW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] slot(input logic v, input logic [3:0] d, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] op,
                                           input logic [2:0] br, input logic [4:0] im);
        return {v, d, a, b, op, br, im};
    endfunction

    // Test-2 bundle: one load among ALU ops
    logic [IW-1:0] t2s1, t2s2, t2s3, t2s4;
    logic [4*IW-1:0] b2;
    // Test-3 bundle: LD, ST, ADD, LD
    logic [IW-1:0] t3s1, t3s2, t3s3, t3s4;
    logic [IW-1:0] t3s1x, t3s2x, t3s3x, t3s4x;
    logic [4*IW-1:0] b3, b3p1, b3p2, b3p3;
    logic [4*IW-1:0] fill [5];
    logic [4*IW-1:0] empty_b;

    initial begin
        t2s1 = slot(1'b1, 4'd1, 4'd2, 4'd3, ADD, 3'd1, 5'd4);
        t2s2 = slot(1'b1, 4'd5, 4'd6, 4'd7, LD,  3'd2, 5'd8);
        t2s3 = slot(1'b1, 4'd9, 4'd10, 4'd11, SUB, 3'd3, 5'd12);
        t2s4 = slot(1'b1, 4'd13, 4'd14, 4'd15, ADD, 3'd4, 5'd16);
        b2   = {t2s4, t2s3, t2s2, t2s1};

        t3s1 = slot(1'b1, 4'd2, 4'd3, 4'd4, LD,  3'd5, 5'd17);
        t3s2 = slot(1'b1, 4'd6, 4'd7, 4'd8, ST,  3'd6, 5'd18);
        t3s3 = slot(1'b1, 4'd10, 4'd11, 4'd12, ADD, 3'd7, 5'd19);
        t3s4 = slot(1'b1, 4'd14, 4'd15, 4'd1, LD,  3'd0, 5'd20);
        t3s1x = slot(1'b0, 4'd2, 4'd3, 4'd4, LD,  3'd5, 5'd17);
        t3s2x = slot(1'b0, 4'd6, 4'd7, 4'd8, ST,  3'd6, 5'd18);
        t3s3x = slot(1'b0, 4'd10, 4'd11, 4'd12, ADD, 3'd7, 5'd19);
        t3s4x = slot(1'b0, 4'd14, 4'd15, 4'd1, LD,  3'd0, 5'd20);
        b3   = {t3s4, t3s3, t3s2, t3s1};
        b3p1 = {t3s4x, t3s3, t3s2x, t3s1};
        b3p2 = {t3s4x, t3s3x, t3s2, t3s1x};
        b3p3 = {t3s4, t3s3x, t3s2x, t3s1x};

        for (int i = 0; i < 5; i++) begin
            fill[i] = {slot(1'b1, 4'(i), 4'(i+1), 4'(i+2), ADD, 3'(i), 5'(i)),
                       slot(1'b1, 4'(i+3), 4'(i), 4'(i), SUB, 3'(i), 5'(i+1)),
                       slot(1'b0, 4'(i), 4'(i), 4'(i), ADD, 3'(i), 5'(i+2)),
                       slot(1'b1, 4'(i+5), 4'(i+6), 4'(i), ADD, 3'(i), 5'(i+3))};
        end
        empty_b = {slot(1'b0, 4'd1, 4'd1, 4'd1, LD, 3'd1, 5'd1),
                   slot(1'b0, 4'd2, 4'd2, 4'd2, ADD, 3'd2, 5'd2),
                   slot(1'b0, 4'd3, 4'd3, 4'd3, ST, 3'd3, 5'd3),
                   slot(1'b0, 4'd4, 4'd4, 4'd4, SUB, 3'd4, 5'd4)};

        // 1: reset state
        #12;
        check("rst_out_valid", 100'(out_valid), 100'(0));
        check("rst_in_ready",  100'(in_ready),  100'(1));
        check("rst_count",     100'(count),     100'(0));
        check("rst_out_swap",  100'(out_swap),  100'(0));
        check("rst_out_ins",   out_ins,         100'(0));
        check("rst_out_last",  100'(out_last),  100'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 2: single-pass bundle with one load
        @(negedge clk);
        in_valid = 1'b1; in_ins = b2; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_valid", 100'(out_valid), 100'(1));
        check("t2_swap",  100'(out_swap),  100'(4'b0010));
        check("t2_last",  100'(out_last),  100'(1));
        check("t2_ins",   out_ins,         b2);
        @(negedge clk);
        check("t2_count", 100'(count), 100'(0));
        check("t2_idle",  100'(out_valid), 100'(0));

        // 3: three passes, with a push alongside the first (non-last) fire
        in_valid = 1'b1; in_ins = b3;
        @(negedge clk);
        in_ins = b2;
        check("t3_p1_swap", 100'(out_swap), 100'(4'b0001));
        check("t3_p1_last", 100'(out_last), 100'(0));
        check("t3_p1_ins",  out_ins,        b3p1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_push_fire_count", 100'(count), 100'(2));
        check("t3_p2_swap", 100'(out_swap), 100'(4'b0010));
        check("t3_p2_last", 100'(out_last), 100'(0));
        check("t3_p2_ins",  out_ins,        b3p2);
        @(negedge clk);
        check("t3_p3_swap", 100'(out_swap), 100'(4'b1000));
        check("t3_p3_last", 100'(out_last), 100'(1));
        check("t3_p3_ins",  out_ins,        b3p3);
        @(negedge clk);
        check("t3_next_count", 100'(count), 100'(1));
        check("t3_next_ins",   out_ins,     b2);
        check("t3_next_swap",  100'(out_swap), 100'(4'b0010));
        @(negedge clk);
        check("t3_drained", 100'(count), 100'(0));

        // 4: backpressure, fill to full, fifth rejected, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_ins = fill[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t4_full_count", 100'(count),    100'(4));
        check("t4_full_ready", 100'(in_ready), 100'(0));
        check("t4_stall_ins",  out_ins,        fill[0]);
        @(negedge clk);
        check("t4_stall_hold", out_ins,        fill[0]);
        check("t4_stall_last", 100'(out_last), 100'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_drain%0d", i), out_ins, fill[i]);
            @(negedge clk);
        end
        check("t4_empty_count", 100'(count), 100'(0));

        // 5: flush during pass 2; same-cycle push ignored, then restart at pass 1
        in_valid = 1'b1; in_ins = b3;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_p1_swap", 100'(out_swap), 100'(4'b0001));
        @(negedge clk);
        check("t5_p2_swap", 100'(out_swap), 100'(4'b0010));
        flush = 1'b1; in_valid = 1'b1; in_ins = b2;
        #1;
        check("t5_flush_valid", 100'(out_valid), 100'(0));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("t5_post_count", 100'(count),     100'(0));
        check("t5_post_valid", 100'(out_valid), 100'(0));
        in_valid = 1'b1; in_ins = b3;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_restart_swap", 100'(out_swap), 100'(4'b0001));
        check("t5_restart_ins",  out_ins,        b3p1);
        @(negedge clk);

        // async reset mid-split
        check("rst_mid_pre_swap", 100'(out_swap), 100'(4'b0010));
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", 100'(count),     100'(0));
        check("rst_mid_valid", 100'(out_valid), 100'(0));
        check("rst_mid_swap",  100'(out_swap),  100'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 6: all-invalid bundle accepted but not stored
        in_valid = 1'b1; in_ins = empty_b;
        #1;
        check("t6_ready", 100'(in_ready), 100'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_count", 100'(count),     100'(0));
        check("t6_valid", 100'(out_valid), 100'(0));
        @(negedge clk);
        check("t6_count2", 100'(count), 100'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
